approx_adder_pipe: RTL and testbench

- Parametrised, pipelined approximate adder: the sequential successor to the fixed 4-bit XPAT-approximated adders.
- Computes the WIDTH+1-bit sum of two WIDTH-bit operands in one of three run-time selectable modes: exact, lower-part-OR (LOA) or lower-part truncation.
- Also computes the exact sum alongside and keeps running error statistics against threshold ET, so error behaviour is measured in-system.
- Sits between a valid/ready operand source and a valid/ready result sink.

---
 rtl/approx_adder_pipe.sv | 164 ++++++++++++++++
 tb/tb_approx_adder_pipe.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_adder_pipe.sv
// Two-stage pipelined approximate adder (exact / lower-part-OR / truncation)
// with an exact reference path and in-system error statistics.
module approx_adder_pipe #(
    parameter int WIDTH       = 4,
    parameter int APPROX_BITS = 2,
    parameter int ET          = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic [WIDTH:0]   out_err,
    output logic             out_viol,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] stat_txn,
    output logic [CNT_W-1:0] stat_viol,
    output logic [WIDTH:0]   stat_max_err,
    output logic             stat_sticky
);
    localparam int W1 = WIDTH + 1;
    localparam int K  = APPROX_BITS;
    localparam int CI = (K > 0) ? K - 1 : 0;
    localparam logic [W1-1:0] LOW_MASK = (W1'(1) << K) - W1'(1);

    typedef enum logic [1:0] {
        MODE_EXACT = 2'b00,
        MODE_LOA   = 2'b01,
        MODE_TRUNC = 2'b10
    } mode_e;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [1:0]       s1_mode_q, s1_mode_d;
    logic             s2_valid_q, s2_valid_d;
    logic [W1-1:0]    s2_sum_q, s2_sum_d, s2_err_q, s2_err_d;
    logic             s2_viol_q, s2_viol_d;
    logic [CNT_W-1:0] stat_txn_q, stat_txn_d, stat_viol_q, stat_viol_d;
    logic [W1-1:0]    stat_max_q, stat_max_d;
    logic             stat_sticky_q, stat_sticky_d;

    // Handshake: a beat moves on a rising edge where valid & ready are both high.
    // A stage may load whenever it is empty or its content moves on this edge,
    // so in_ready depends combinationally on out_ready through s2_adv.
    logic s2_adv, s1_adv, deliver;
    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_adv;
    assign in_ready = !s1_valid_q || s2_adv;
    assign deliver  = s2_valid_q && out_ready;

    logic [W1-1:0] a_ext, b_ext, exact, hi_sum, approx, err;
    logic          loa_c, viol;

    always_comb begin
        a_ext  = {1'b0, s1_a_q};
        b_ext  = {1'b0, s1_b_q};
        exact  = a_ext + b_ext;
        // Upper parts are added in place, so K=WIDTH naturally yields zero.
        hi_sum = (a_ext & ~LOW_MASK) + (b_ext & ~LOW_MASK);
        loa_c  = (K > 0) && s1_a_q[CI] && s1_b_q[CI];
        case (mode_e'(s1_mode_q))
            MODE_LOA:   approx = (hi_sum + (W1'(loa_c) << K)) | ((a_ext | b_ext) & LOW_MASK);
            MODE_TRUNC: approx = hi_sum;
            default:    approx = exact;
        endcase
        err  = (exact >= approx) ? (exact - approx) : (approx - exact);
        viol = 32'(err) > 32'(ET);
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_mode_d  = s1_mode_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d    = in_a;
                s1_b_d    = in_b;
                s1_mode_d = in_mode;
            end
        end

        s2_valid_d = s2_valid_q;
        s2_sum_d   = s2_sum_q;
        s2_err_d   = s2_err_q;
        s2_viol_d  = s2_viol_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_adv) begin
                s2_sum_d  = approx;
                s2_err_d  = err;
                s2_viol_d = viol;
            end
        end
    end

    always_comb begin
        stat_txn_d    = stat_txn_q;
        stat_viol_d   = stat_viol_q;
        stat_max_d    = stat_max_q;
        stat_sticky_d = stat_sticky_q;
        // A clear on the same edge as a delivery discards that delivery.
        if (clr_stats) begin
            stat_txn_d    = '0;
            stat_viol_d   = '0;
            stat_max_d    = '0;
            stat_sticky_d = 1'b0;
        end else if (deliver) begin
            if (stat_txn_q != {CNT_W{1'b1}}) stat_txn_d = stat_txn_q + CNT_W'(1);
            if (s2_viol_q) begin
                if (stat_viol_q != {CNT_W{1'b1}}) stat_viol_d = stat_viol_q + CNT_W'(1);
                stat_sticky_d = 1'b1;
            end
            if (s2_err_q > stat_max_q) stat_max_d = s2_err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_a_q        <= '0;
            s1_b_q        <= '0;
            s1_mode_q     <= '0;
            s2_valid_q    <= 1'b0;
            s2_sum_q      <= '0;
            s2_err_q      <= '0;
            s2_viol_q     <= 1'b0;
            stat_txn_q    <= '0;
            stat_viol_q   <= '0;
            stat_max_q    <= '0;
            stat_sticky_q <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_a_q        <= s1_a_d;
            s1_b_q        <= s1_b_d;
            s1_mode_q     <= s1_mode_d;
            s2_valid_q    <= s2_valid_d;
            s2_sum_q      <= s2_sum_d;
            s2_err_q      <= s2_err_d;
            s2_viol_q     <= s2_viol_d;
            stat_txn_q    <= stat_txn_d;
            stat_viol_q   <= stat_viol_d;
            stat_max_q    <= stat_max_d;
            stat_sticky_q <= stat_sticky_d;
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_sum      = s2_sum_q;
    assign out_err      = s2_err_q;
    assign out_viol     = s2_viol_q;
    assign stat_txn     = stat_txn_q;
    assign stat_viol    = stat_viol_q;
    assign stat_max_err = stat_max_q;
    assign stat_sticky  = stat_sticky_q;

endmodule

// File: tb/tb_approx_adder_pipe.sv
// Bench for approx_adder_pipe: arithmetic reference model, scoreboard queue,
// stall-hold and statistics checks, directed cases plus random traffic.
module tb_approx_adder_pipe;
    localparam int WIDTH = 4;
    localparam int K     = 2;
    localparam int ET    = 4;
    localparam int CNT_W = 16;
    localparam int W1    = WIDTH + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [1:0]       in_mode = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [W1-1:0]    out_sum, out_err;
    logic             out_viol;
    logic             clr_stats = 1'b0;
    logic [CNT_W-1:0] stat_txn, stat_viol;
    logic [W1-1:0]    stat_max_err;
    logic             stat_sticky;

    approx_adder_pipe #(.WIDTH(WIDTH), .APPROX_BITS(K), .ET(ET), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_err(out_err), .out_viol(out_viol),
        .clr_stats(clr_stats),
        .stat_txn(stat_txn), .stat_viol(stat_viol),
        .stat_max_err(stat_max_err), .stat_sticky(stat_sticky)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int rdy_mode = 0;   // 0: always ready, 1: toggle, 2: random, 3: never ready
    bit started  = 0;

    logic [2*W1:0] exp_q[$];   // {viol, err, sum}
    int m_txn, m_viol, m_max;
    bit m_sticky;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference written from the arithmetic definition of each mode.
    function automatic logic [2*W1:0] model(input int a, input int b, input int m);
        int ah, bh, al, bl, c, ex, ap, e;
        ah = a / (1 << K);  bh = b / (1 << K);
        al = a % (1 << K);  bl = b % (1 << K);
        c  = 0;
        if (K > 0) c = ((a >> (K - 1)) & (b >> (K - 1))) & 1;
        ex = a + b;
        case (m)
            1:       ap = (ah + bh + c) * (1 << K) + (al | bl);
            2:       ap = (ah + bh) * (1 << K);
            default: ap = ex;
        endcase
        e = (ex > ap) ? ex - ap : ap - ex;
        return {(e > ET) ? 1'b1 : 1'b0, W1'(e), W1'(ap)};
    endfunction

    initial forever begin
        @(posedge clk); #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Compare process: everything is sampled on the falling edge, and the
    // handshakes seen here take effect on the following rising edge.
    bit            stall_prev = 0;
    logic [2*W1:0] held;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_txn = 0; m_viol = 0; m_max = 0; m_sticky = 0;
            stall_prev = 0;
        end else if (started) begin
            chk("stat_txn", 32'(stat_txn), 32'(m_txn));
            chk("stat_viol", 32'(stat_viol), 32'(m_viol));
            chk("stat_max_err", 32'(stat_max_err), 32'(m_max));
            chk("stat_sticky", 32'(stat_sticky), 32'(m_sticky));
            if (stall_prev) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'({out_viol, out_err, out_sum}), 32'(held));
            end
            if (out_valid && exp_q.size() == 0) chk("spurious_out_valid", 32'(out_valid), 32'd0);
            if (out_valid && out_ready && exp_q.size() > 0) begin
                logic [2*W1:0] e;
                e = exp_q.pop_front();
                chk("out_sum", 32'(out_sum), 32'(e[W1-1:0]));
                chk("out_err", 32'(out_err), 32'(e[2*W1-1:W1]));
                chk("out_viol", 32'(out_viol), 32'(e[2*W1]));
            end
            if (clr_stats) begin
                m_txn = 0; m_viol = 0; m_max = 0; m_sticky = 0;
            end else if (out_valid && out_ready) begin
                if (m_txn < (1 << CNT_W) - 1) m_txn++;
                if (out_viol) begin
                    if (m_viol < (1 << CNT_W) - 1) m_viol++;
                    m_sticky = 1;
                end
                if (int'(out_err) > m_max) m_max = int'(out_err);
            end
            if (in_valid && in_ready) exp_q.push_back(model(int'(in_a), int'(in_b), int'(in_mode)));
            stall_prev = out_valid && !out_ready;
            held = {out_viol, out_err, out_sum};
        end
    end

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic send(input int a, input int b, input int m);
        int t = 0;
        in_a = WIDTH'(a); in_b = WIDTH'(b); in_mode = 2'(m); in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 100) begin @(negedge clk); t++; end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input int sum, input int err, input int viol);
        int t = 0;
        @(negedge clk);
        while (!(out_valid && out_ready) && t < 50) begin @(negedge clk); t++; end
        chk({name, "_valid"}, 32'(out_valid && out_ready), 32'd1);
        chk({name, "_sum"}, 32'(out_sum), 32'(sum));
        chk({name, "_err"}, 32'(out_err), 32'(err));
        chk({name, "_viol"}, 32'(out_viol), 32'(viol));
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int t = 0;
        @(negedge clk);
        while (!(exp_q.size() == 0 && !out_valid) && t < 500) begin @(negedge clk); t++; end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic clear_stats();
        clr_stats = 1'b1;
        @(posedge clk); #1;
        clr_stats = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_stat_txn", 32'(stat_txn), 32'd0);
        chk("rst_stat_max", 32'(stat_max_err), 32'd0);
        started = 1;
        @(posedge clk); #1;

        // Exact 15+15 with latency check.
        send(15, 15, 0);
        @(negedge clk);
        chk("lat_n1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_n2_valid", 32'(out_valid), 32'd1);
        chk("exact_sum", 32'(out_sum), 32'd30);
        chk("exact_err", 32'(out_err), 32'd0);
        @(posedge clk); #1;
        drain();

        // LOA cases.
        clear_stats();
        send(3, 1, 1);
        expect_out("loa31", 3, 1, 0);
        send(3, 3, 1);
        expect_out("loa33", 7, 1, 0);
        drain();
        chk("t2_txn", 32'(stat_txn), 32'd2);
        chk("t2_max", 32'(stat_max_err), 32'd1);
        chk("t2_sticky", 32'(stat_sticky), 32'd0);

        // Truncation with violation.
        send(7, 7, 2);
        expect_out("trunc77", 8, 6, 1);
        drain();
        chk("t3_viol", 32'(stat_viol), 32'd1);
        chk("t3_sticky", 32'(stat_sticky), 32'd1);
        chk("t3_max", 32'(stat_max_err), 32'd6);

        // Burst under toggling out_ready.
        clear_stats();
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3));
        drain();
        chk("t4_txn", 32'(stat_txn), 32'd8);
        rdy_mode = 0;
        @(posedge clk); #1;

        // Clear coincident with a violating delivery.
        send(7, 7, 2);
        @(posedge clk); #1;
        chk("t5_coincide", 32'(out_valid && out_ready), 32'd1);
        clr_stats = 1'b1;
        @(posedge clk); #1;
        clr_stats = 1'b0;
        @(negedge clk);
        chk("t5_txn", 32'(stat_txn), 32'd0);
        chk("t5_viol", 32'(stat_viol), 32'd0);
        chk("t5_max", 32'(stat_max_err), 32'd0);
        chk("t5_sticky", 32'(stat_sticky), 32'd0);
        @(posedge clk); #1;
        send(7, 7, 2);
        drain();
        chk("t5_viol_after", 32'(stat_viol), 32'd1);

        // Reset with both stages full.
        rdy_mode = 3;
        @(posedge clk); #1;
        send(5, 6, 0);
        send(9, 2, 1);
        @(negedge clk);
        chk("t6_full_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rdy_mode = 0;
        @(negedge clk);
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        chk("t6_stat_txn", 32'(stat_txn), 32'd0);
        chk("t6_stat_viol", 32'(stat_viol), 32'd0);
        @(posedge clk); #1;
        send(12, 9, 0);
        expect_out("t6_after", 21, 0, 0);
        drain();

        // Random traffic.
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end
        drain();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, limit %0d", 200000);
        $fatal(1, "timeout");
    end

endmodule
